sys_mem_responder: RTL and testbench

System-bus memory responder: the far end of the bus that the cache controller drives on misses and write-throughs. It samples a one-cycle `SysStrobe` command (address plus 4-bit byte-lane `SysRW`) and waits a fixed number of cycles. It then returns read data on the shared bidirectional `SysData` bus, or commits write data into a byte-addressable backing store. Response latency is fixed and matches the initiator's wait-state counter, so the initiator needs no ready handshake; `SysReady` is provided for benches and future initiators.

---
 rtl/sys_bus_pkg.sv | 18 +
 rtl/sys_wait_ctr.sv | 34 +++
 rtl/sys_mem_responder.sv | 134 +++++++++++++
 tb/tb_sys_mem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Shared system-bus definitions used by both the cache controller and the
// memory responder, so the wait-state count cannot drift between the two ends.
package sys_bus_pkg;

   localparam int         WAITSTATES    = 3;
   localparam int         SYS_DATA_W    = 32;
   localparam int         SYS_ADDR_W    = 16;
   localparam int         SYS_MEM_WORDS = 1024;
   localparam int         SYS_LANES     = SYS_DATA_W / 8;
   localparam logic [3:0] SYS_READ      = 4'b0000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } resp_state_e;

endpackage

// File: rtl/sys_wait_ctr.sv
// Loadable down-counter that times the responder's fixed latency.
// It loads WAIT_STATES, counts down to zero, and then holds at zero.
module sys_wait_ctr
   import sys_bus_pkg::*;
#(
   parameter int WAIT_STATES = WAITSTATES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int            CW       = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_STATES);

   logic [CW-1:0] count;

   // Counter register: synchronous clear, load on a new command, then count down.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (dec && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/sys_mem_responder.sv
// System-bus memory responder. It accepts a one-cycle strobe, waits a fixed
// latency, and then either drives read data onto the shared bus for exactly one
// cycle or commits the byte lanes of write data into the backing store.
module sys_mem_responder
   import sys_bus_pkg::*;
#(
   parameter int WAIT_STATES = WAITSTATES,
   parameter int ADDR_W      = SYS_ADDR_W,
   parameter int MEM_WORDS   = SYS_MEM_WORDS
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  SysStrobe,
   input  logic [ADDR_W-1:0]     SysAddress,
   input  logic [3:0]            SysRW,
   inout  wire  [SYS_DATA_W-1:0] SysData,
   output logic                  SysReady,
   output logic                  SysBusy
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   resp_state_e           state;
   resp_state_e           next_state;
   logic [IDX_W-1:0]      idx_q;
   logic [3:0]            rw_q;
   logic [SYS_DATA_W-1:0] data_q;
   logic                  cmd_take;
   logic                  data_take;
   logic                  mem_commit;
   logic                  ctr_load;
   logic                  ctr_dec;
   logic                  ctr_zero;
   logic                  drive_en;

   // Byte store: one array per lane, so partial writes touch only the enabled lanes.
   logic [7:0] lane_mem [SYS_LANES][MEM_WORDS];

   // The byte offset and the address bits above the word index are deliberately
   // dropped, so addresses alias modulo the store size.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{SysAddress[ADDR_W-1:IDX_W+2], SysAddress[1:0]};

   sys_wait_ctr #(
      .WAIT_STATES(WAIT_STATES)
   ) u_wait_ctr (
      .clk  (Clk),
      .rst_n(Reset),
      .load (ctr_load),
      .dec  (ctr_dec),
      .zero (ctr_zero)
   );

   // State register: reset aborts any in-flight access.
   always_ff @(posedge Clk) begin
      if (!Reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic: strobes outside IDLE are ignored.
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (SysStrobe) next_state = WAIT;
         WAIT:    if (ctr_zero)  next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Per-state control strobes for the counter, command latch and store.
   always_comb begin
      cmd_take   = 1'b0;
      ctr_load   = 1'b0;
      ctr_dec    = 1'b0;
      data_take  = 1'b0;
      mem_commit = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_take = SysStrobe;
            ctr_load = SysStrobe;
         end
         WAIT: begin
            data_take = ctr_zero;
            ctr_dec   = !ctr_zero;
         end
         RESP:    mem_commit = Reset && (rw_q != SYS_READ);
         default: ;
      endcase
   end

   // Registered handshake outputs, derived from the state being entered so they are glitch-free.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         SysReady <= 1'b0;
         SysBusy  <= 1'b0;
      end else begin
         SysReady <= (next_state == RESP);
         SysBusy  <= (next_state != IDLE);
      end
   end

   // Command latch: word index and byte-lane enables of the accepted strobe.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         idx_q <= '0;
         rw_q  <= SYS_READ;
      end else if (cmd_take) begin
         idx_q <= SysAddress[IDX_W+1:2];
         rw_q  <= SysRW;
      end
   end

   // Backing store and read-data register: lane-masked write in RESP, word read at the end of WAIT.
   // NOTE: the store is deliberately not reset; contents survive Reset like a real memory array.
   always_ff @(posedge Clk) begin
      if (mem_commit) begin
         for (int l = 0; l < SYS_LANES; l++) begin
            if (rw_q[l]) lane_mem[l][idx_q] <= SysData[8*l +: 8];
         end
      end
      if (data_take) begin
         for (int l = 0; l < SYS_LANES; l++) begin
            data_q[8*l +: 8] <= lane_mem[l][idx_q];
         end
      end
   end

   // The bus is driven only in the response cycle of a read; both terms are flops.
   assign drive_en = SysReady && (rw_q == SYS_READ);
   assign SysData  = drive_en ? data_q : 'z;

endmodule

// File: tb/tb_sys_mem_responder.sv
// Directed bench for sys_mem_responder. Inputs change and outputs are sampled
// 1 time unit after each rising edge. The bus carries a pull-up, so an
// undriven SysData reads as all ones.
module tb_sys_mem_responder;

   localparam logic [31:0] BUS_IDLE = 32'hFFFF_FFFF;

   logic        Clk;
   logic        Reset;
   logic        SysStrobe;
   logic [15:0] SysAddress;
   logic [3:0]  SysRW;
   wire  [31:0] SysData;
   logic        SysReady;
   logic        SysBusy;

   logic        tb_drv;
   logic [31:0] tb_data;

   int n_asserts = 0;
   int n_fail    = 0;

   assign SysData = tb_drv ? tb_data : 'z;
   pullup (SysData);

   sys_mem_responder dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .SysStrobe (SysStrobe),
      .SysAddress(SysAddress),
      .SysRW     (SysRW),
      .SysData   (SysData),
      .SysReady  (SysReady),
      .SysBusy   (SysBusy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One complete access starting in the current cycle N. For a write, data is
   // the write value; for a read, it is the value required in the response cycle.
   // Returns in cycle N+6, the first cycle a new strobe may be accepted.
   task automatic access(input string tag, input logic [15:0] addr, input logic [3:0] rw,
                         input logic [31:0] data);
      SysStrobe  = 1'b1;
      SysAddress = addr;
      SysRW      = rw;
      tick();
      SysStrobe = 1'b0;
      if (rw != 4'b0000) begin
         tb_drv  = 1'b1;
         tb_data = data;
      end
      #1;
      for (int c = 1; c <= 4; c++) begin
         check($sformatf("%s busy N+%0d", tag, c), 32'(SysBusy), 32'd1);
         check($sformatf("%s ready N+%0d", tag, c), 32'(SysReady), 32'd0);
         if (rw == 4'b0000) check($sformatf("%s bus N+%0d", tag, c), SysData, BUS_IDLE);
         tick();
      end
      check($sformatf("%s ready N+5", tag), 32'(SysReady), 32'd1);
      check($sformatf("%s busy N+5", tag), 32'(SysBusy), 32'd1);
      if (rw == 4'b0000) check($sformatf("%s data N+5", tag), SysData, data);
      tick();
      tb_drv = 1'b0;
      #1;
      check($sformatf("%s ready N+6", tag), 32'(SysReady), 32'd0);
      check($sformatf("%s busy N+6", tag), 32'(SysBusy), 32'd0);
      check($sformatf("%s bus N+6", tag), SysData, BUS_IDLE);
   endtask

   initial begin
      Reset      = 1'b0;
      SysStrobe  = 1'b0;
      SysAddress = '0;
      SysRW      = 4'b0000;
      tb_drv     = 1'b0;
      tb_data    = '0;

      // Reset state
      repeat (3) tick();
      check("reset ready", 32'(SysReady), 32'd0);
      check("reset busy", 32'(SysBusy), 32'd0);
      check("reset bus", SysData, BUS_IDLE);

      // Full write then read; the first strobe lands in the first cycle out of reset
      Reset = 1'b1;
      access("wr40", 16'h0040, 4'b1111, 32'hDEAD_BEEF);
      access("rd40", 16'h0040, 4'b0000, 32'hDEAD_BEEF);

      // Partial write: lanes 0 and 2 only
      access("pre100", 16'h0100, 4'b1111, 32'h1122_3344);
      access("part100", 16'h0100, 4'b0101, 32'hAABB_CCDD);
      access("rd100", 16'h0100, 4'b0000, 32'h11BB_33DD);

      // Aliasing above the index, and byte offset ignored
      access("wr004", 16'h0004, 4'b1111, 32'h1234_5678);
      access("rd1004", 16'h1004, 4'b0000, 32'h1234_5678);
      access("rd006", 16'h0006, 4'b0000, 32'h1234_5678);

      // Strobe while busy: a write strobe at N+2 must be ignored
      SysStrobe  = 1'b1;
      SysAddress = 16'h0040;
      SysRW      = 4'b0000;
      tick();                                   // N+1
      SysStrobe = 1'b0;
      tick();                                   // N+2
      SysStrobe  = 1'b1;
      SysAddress = 16'h0100;
      SysRW      = 4'b1111;
      tick();                                   // N+3
      SysStrobe = 1'b0;
      check("busy-strobe ready N+3", 32'(SysReady), 32'd0);
      tick();                                   // N+4
      check("busy-strobe ready N+4", 32'(SysReady), 32'd0);
      check("busy-strobe bus N+4", SysData, BUS_IDLE);
      tick();                                   // N+5
      check("busy-strobe ready N+5", 32'(SysReady), 32'd1);
      check("busy-strobe data N+5", SysData, 32'hDEAD_BEEF);
      tick();                                   // N+6
      check("busy-strobe ready N+6", 32'(SysReady), 32'd0);
      check("busy-strobe busy N+6", 32'(SysBusy), 32'd0);
      // Strobe at N+6 responds at N+11; also shows 0x0100 was not overwritten
      access("rd100-after", 16'h0100, 4'b0000, 32'h11BB_33DD);

      // Reset during a write of all ones over all zeros
      access("zero200", 16'h0200, 4'b1111, 32'h0000_0000);
      SysStrobe  = 1'b1;
      SysAddress = 16'h0200;
      SysRW      = 4'b1111;
      tick();                                   // N+1
      SysStrobe = 1'b0;
      tb_drv    = 1'b1;
      tb_data   = 32'hFFFF_FFFF;
      tick();                                   // N+2
      tick();                                   // N+3
      Reset = 1'b0;
      tick();                                   // N+4, reset taken
      tb_drv = 1'b0;
      #1;
      check("rst-mid ready", 32'(SysReady), 32'd0);
      check("rst-mid busy", 32'(SysBusy), 32'd0);
      check("rst-mid bus", SysData, BUS_IDLE);
      tick();                                   // N+5, still in reset
      check("rst-mid ready N+5", 32'(SysReady), 32'd0);
      check("rst-mid busy N+5", 32'(SysBusy), 32'd0);
      Reset = 1'b1;
      tick();
      check("rst-after busy", 32'(SysBusy), 32'd0);
      access("rd200", 16'h0200, 4'b0000, 32'h0000_0000);

      // Back-to-back: fill 16 words, then read them back every 8 cycles
      for (int i = 0; i < 16; i++) begin
         access($sformatf("b2b-wr%0d", i), 16'h0300 + 16'(4 * i), 4'b1111,
                32'h1000_0000 + 32'(i) * 32'h0103_0507);
      end
      for (int i = 0; i < 16; i++) begin
         access($sformatf("b2b-rd%0d", i), 16'h0300 + 16'(4 * i), 4'b0000,
                32'h1000_0000 + 32'(i) * 32'h0103_0507);
         for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("b2b-gap%0d.%0d bus", i, k), SysData, BUS_IDLE);
            check($sformatf("b2b-gap%0d.%0d ready", i, k), 32'(SysReady), 32'd0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
